store_buffer: RTL and testbench

//  Posted-write FIFO between the mips data port (memwrite/memaddr/memwritedata/memreaddata) and a slow

---
 rtl/store_buffer_if.sv | 47 ++++
 rtl/store_buffer.sv | 155 +++++++++++++++
 tb/tb_store_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : store_buffer_if
// Description : Bundles the two channels of the store buffer.
//               The core side is the mips data port: store/load strobes,
//               address, store data, load data and stall.
//               The memory side is a req/ready request channel plus a
//               one-cycle rvalid read-return channel.
//               slave  : the store buffer's view of the bundle.
//               master : the environment's view (core and memory).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // core side
    logic          cpu_memwrite;
    logic          cpu_memread;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    // memory side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_memwrite, cpu_memread, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output cpu_memwrite, cpu_memread, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : store_buffer
// Description : Posted-write FIFO between the mips data port and a slow data
//               memory. A SW retires in one cycle when an entry is free. A LW
//               forwards from the youngest matching buffered store.
//               Otherwise the LW stalls the core until memory returns data.
//               Word accesses only.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous reset, active low
//               bus   - store_buffer_if.slave (core and memory channels)
//               count - number of occupied entries
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    store_buffer_if.slave               bus,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_LREQ  = 3'd2;
    localparam logic [2:0] S_LWAIT = 3'd3;
    localparam logic [2:0] S_LDONE = 3'd4;

    logic [2:0]    r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic          w_hit;
    logic          w_miss;
    logic [DW-1:0] w_fwd;
    logic [PW-1:0] w_idx;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A full buffer refuses the SW even if the head drains this cycle.
    assign w_enq   = bus.cpu_memwrite & ~w_full;
    assign w_deq   = (r_state == S_DRAIN) & bus.mem_ready;
    assign w_miss  = bus.cpu_memread & ~w_hit;
    assign count   = r_count;

    // Walk the valid entries oldest to youngest; a later match overrides an
    // earlier one, so the youngest matching store wins.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + i[PW-1:0];
            if ((i < int'(r_count)) &&
                (r_addr[w_idx][AW-1:2] == bus.cpu_addr[AW-1:2])) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    // Core-facing outputs depend on live inputs, so they are gated by reset
    // to read zero while reset is held.
    always_comb begin
        bus.cpu_stall = 1'b0;
        bus.cpu_rdata = '0;
        if (reset) begin
            bus.cpu_stall = (bus.cpu_memwrite & w_full) |
                            (w_miss & (r_state != S_LDONE));
            if (r_state == S_LDONE) begin
                bus.cpu_rdata = r_rdata;
            end else if (bus.cpu_memread & w_hit) begin
                bus.cpu_rdata = w_fwd;
            end
        end
    end

    // Request fields come from registered state and the head entry, which only
    // moves on a handshake; the load address is held by the stalled core.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (r_state)
            S_DRAIN: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = r_addr[r_rd_ptr];
                bus.mem_wdata = r_data[r_rd_ptr];
            end
            S_LREQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = bus.cpu_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);

            case (r_state)
                S_IDLE: begin
                    // Loads take priority over draining.
                    if (w_miss)        r_state <= S_LREQ;
                    else if (!w_empty) r_state <= S_DRAIN;
                end
                S_DRAIN: if (bus.mem_ready) r_state <= S_IDLE;
                S_LREQ:  if (bus.mem_ready) r_state <= S_LWAIT;
                S_LWAIT: begin
                    if (bus.mem_rvalid) begin
                        r_rdata <= bus.mem_rdata;
                        r_state <= S_LDONE;
                    end
                end
                S_LDONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Entry storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= bus.cpu_addr;
            r_data[r_wr_ptr] <= bus.cpu_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A vector table covers
//               buffering, draining, store stall, and forwarding. Hand-written
//               sequences cover load miss, load behind a drain, and reset
//               during a load.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_store_buffer;

    logic       clk;
    logic       reset;
    logic [2:0] count;

    int n_cmp = 0;
    int n_err = 0;

    store_buffer_if #(.AW(32), .DW(32)) bus ();

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        mw, mr;
        logic [31:0] a, d;
        logic        rdy;
        logic        e_stall;
        logic [31:0] e_rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic mw, logic mr, logic [31:0] a, logic [31:0] d,
                               logic rdy, logic es, logic [31:0] erd, logic ereq,
                               logic ewe, logic [31:0] ea, logic [31:0] ewd,
                               logic [2:0] ec);
        vec_t r;
        r.mw = mw; r.mr = mr; r.a = a; r.d = d; r.rdy = rdy;
        r.e_stall = es; r.e_rdata = erd; r.e_req = ereq; r.e_we = ewe;
        r.e_addr = ea; r.e_wdata = ewd; r.e_cnt = ec;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic es, input logic [31:0] erd,
                           input logic ereq, input logic ewe, input logic [31:0] ea,
                           input logic [31:0] ewd, input logic [2:0] ec);
        chk({tag, " stall"}, 32'(bus.cpu_stall), 32'(es));
        chk({tag, " rdata"}, bus.cpu_rdata, erd);
        chk({tag, " req"},   32'(bus.mem_req), 32'(ereq));
        chk({tag, " we"},    32'(bus.mem_we), 32'(ewe));
        chk({tag, " addr"},  bus.mem_addr, ea);
        chk({tag, " wdata"}, bus.mem_wdata, ewd);
        chk({tag, " count"}, 32'(count), 32'(ec));
    endtask

    // Drive a cycle's inputs at the falling edge; outputs are checked 1 time
    // unit later, well before the next rising edge.
    task automatic drive(input logic mw, input logic mr, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy, input logic rv,
                         input logic [31:0] rd);
        @(negedge clk);
        bus.cpu_memwrite = mw;
        bus.cpu_memread  = mr;
        bus.cpu_addr     = a;
        bus.cpu_wdata    = d;
        bus.mem_ready    = rdy;
        bus.mem_rvalid   = rv;
        bus.mem_rdata    = rd;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.cpu_memwrite = 1'b0; bus.cpu_memread = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        // --- vector table: buffering, drain order, full stall, forwarding ---
        tbl.push_back(v(0,0,32'h000,32'h0000,0, 0,32'h0,0,0,32'h000,32'h0000,0));
        tbl.push_back(v(1,0,32'h010,32'hAAAA,0, 0,32'h0,0,0,32'h000,32'h0000,0));
        tbl.push_back(v(1,0,32'h014,32'hBBBB,0, 0,32'h0,0,0,32'h000,32'h0000,1));
        tbl.push_back(v(0,0,32'h000,32'h0000,0, 0,32'h0,1,1,32'h010,32'hAAAA,2));
        tbl.push_back(v(0,0,32'h000,32'h0000,0, 0,32'h0,1,1,32'h010,32'hAAAA,2));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,1,1,32'h010,32'hAAAA,2));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,0,0,32'h000,32'h0000,1));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,1,1,32'h014,32'hBBBB,1));
        tbl.push_back(v(0,0,32'h000,32'h0000,0, 0,32'h0,0,0,32'h000,32'h0000,0));
        tbl.push_back(v(1,0,32'h020,32'h0001,0, 0,32'h0,0,0,32'h000,32'h0000,0));
        tbl.push_back(v(1,0,32'h020,32'h0002,0, 0,32'h0,0,0,32'h000,32'h0000,1));
        tbl.push_back(v(0,1,32'h022,32'h0000,0, 0,32'h2,1,1,32'h020,32'h0001,2));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,1,1,32'h020,32'h0001,2));
        tbl.push_back(v(0,1,32'h020,32'h0000,0, 0,32'h2,0,0,32'h000,32'h0000,1));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,1,1,32'h020,32'h0002,1));
        tbl.push_back(v(1,0,32'h100,32'h0011,0, 0,32'h0,0,0,32'h000,32'h0000,0));
        tbl.push_back(v(1,0,32'h104,32'h0022,0, 0,32'h0,0,0,32'h000,32'h0000,1));
        tbl.push_back(v(1,0,32'h108,32'h0033,0, 0,32'h0,1,1,32'h100,32'h0011,2));
        tbl.push_back(v(1,0,32'h10C,32'h0044,0, 0,32'h0,1,1,32'h100,32'h0011,3));
        tbl.push_back(v(1,0,32'h110,32'h0055,0, 1,32'h0,1,1,32'h100,32'h0011,4));
        tbl.push_back(v(1,0,32'h110,32'h0055,0, 1,32'h0,1,1,32'h100,32'h0011,4));
        tbl.push_back(v(1,0,32'h110,32'h0055,1, 1,32'h0,1,1,32'h100,32'h0011,4));
        tbl.push_back(v(1,0,32'h110,32'h0055,0, 0,32'h0,0,0,32'h000,32'h0000,3));
        tbl.push_back(v(0,0,32'h000,32'h0000,0, 0,32'h0,1,1,32'h104,32'h0022,4));
        tbl.push_back(v(0,1,32'h113,32'h0000,0, 0,32'h55,1,1,32'h104,32'h0022,4));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,1,1,32'h104,32'h0022,4));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,0,0,32'h000,32'h0000,3));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,1,1,32'h108,32'h0033,3));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,0,0,32'h000,32'h0000,2));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,1,1,32'h10C,32'h0044,2));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,0,0,32'h000,32'h0000,1));
        tbl.push_back(v(0,0,32'h000,32'h0000,1, 0,32'h0,1,1,32'h110,32'h0055,1));
        tbl.push_back(v(0,0,32'h000,32'h0000,0, 0,32'h0,0,0,32'h000,32'h0000,0));

        // reset state while reset is held
        drive(0,0,0,0,0,0,0);
        chk_all("reset", 0,0,0,0,0,0,0);
        drive(0,0,0,0,0,0,0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].mw, tbl[i].mr, tbl[i].a, tbl[i].d, tbl[i].rdy, 1'b0, 32'h0);
            chk_all($sformatf("row%0d", i), tbl[i].e_stall, tbl[i].e_rdata,
                    tbl[i].e_req, tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata,
                    tbl[i].e_cnt);
        end

        // --- load miss: ready after 2 cycles, rvalid 3 cycles later ---
        drive(0,1,32'h40,0,0,0,0);  chk_all("lw idle",   1,0,0,0,32'h00,0,0);
        drive(0,1,32'h40,0,0,0,0);  chk_all("lw req0",   1,0,1,0,32'h40,0,0);
        drive(0,1,32'h40,0,0,0,0);  chk_all("lw req1",   1,0,1,0,32'h40,0,0);
        drive(0,1,32'h40,0,1,0,0);  chk_all("lw hs",     1,0,1,0,32'h40,0,0);
        drive(0,1,32'h40,0,0,0,0);  chk_all("lw wait0",  1,0,0,0,32'h00,0,0);
        drive(0,1,32'h40,0,0,0,0);  chk_all("lw wait1",  1,0,0,0,32'h00,0,0);
        drive(0,1,32'h40,0,0,1,32'hDEAD); chk_all("lw rv", 1,0,0,0,32'h00,0,0);
        drive(0,1,32'h40,0,0,0,0);  chk_all("lw done",   0,32'hDEAD,0,0,32'h00,0,0);
        drive(0,0,32'h00,0,0,0,0);  chk_all("lw after",  0,0,0,0,32'h00,0,0);

        // --- load miss behind a stalled drain ---
        drive(1,0,32'h80,32'h77,0,0,0); chk_all("dr sw",   0,0,0,0,32'h00,0,0);
        drive(0,0,32'h00,0,0,0,0);      chk_all("dr idle", 0,0,0,0,32'h00,0,1);
        drive(0,1,32'h90,0,0,0,0);      chk_all("dr lw0",  1,0,1,1,32'h80,32'h77,1);
        drive(0,1,32'h90,0,1,0,0);      chk_all("dr hs",   1,0,1,1,32'h80,32'h77,1);
        drive(0,1,32'h90,0,0,0,0);      chk_all("dr lidle",1,0,0,0,32'h00,0,0);
        drive(0,1,32'h90,0,1,0,0);      chk_all("dr lreq", 1,0,1,0,32'h90,0,0);
        drive(0,1,32'h90,0,0,1,32'h1234); chk_all("dr lwait",1,0,0,0,32'h00,0,0);
        drive(0,1,32'h90,0,0,0,0);      chk_all("dr ldone",0,32'h1234,0,0,32'h00,0,0);

        // --- reset during LWAIT with three stores buffered ---
        drive(1,0,32'h200,32'h1,0,0,0);
        drive(1,0,32'h204,32'h2,0,0,0);
        drive(1,0,32'h208,32'h3,0,0,0);
        drive(1,0,32'h20C,32'h4,0,0,0);
        drive(0,1,32'h300,0,1,0,0);     chk_all("rs drain",1,0,1,1,32'h200,32'h1,4);
        drive(0,1,32'h300,0,0,0,0);     chk_all("rs idle", 1,0,0,0,32'h000,0,3);
        drive(0,1,32'h300,0,1,0,0);     chk_all("rs lreq", 1,0,1,0,32'h300,0,3);
        drive(0,1,32'h300,0,0,0,0);     chk_all("rs lwait",1,0,0,0,32'h000,0,3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("rs asserted", 0,0,0,0,32'h000,0,0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all("rs release", 1,0,0,0,32'h000,0,0);
        drive(0,1,32'h300,0,0,0,0);     chk_all("rs fresh",1,0,1,0,32'h300,0,0);
        drive(0,0,32'h000,0,1,0,0);
        drive(0,0,32'h000,0,0,0,0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
